// File: rtl/level_release_delay_if.sv
// Bundle of the request, delay programming and delayed-level status signals
// exchanged between the control/CSR side (master) and level_release_delay (slave).
interface level_release_delay_if;
    logic        enable;
    logic [15:0] assert_delay;
    logic [15:0] release_delay;
    logic        delayed_en;
    logic        busy;
    logic        en_rise;
    logic        en_fall;

    modport master (
        output enable,
        output assert_delay,
        output release_delay,
        input  delayed_en,
        input  busy,
        input  en_rise,
        input  en_fall
    );

    modport slave (
        input  enable,
        input  assert_delay,
        input  release_delay,
        output delayed_en,
        output busy,
        output en_rise,
        output en_fall
    );
endinterface

// File: rtl/level_release_delay.sv
// level_release_delay: two-sided level delay for core-domain enables.
// Assertion of enable is qualified by assert_delay cycles and deassertion is
// stretched by release_delay cycles. A single 16-bit up-counter times both
// directions; the compare is ">=" so a delay lowered below the running count
// completes on the next edge and the counter can never wrap.
module level_release_delay (
    input  logic                        clk_core,
    input  logic                        rst_core_n,
    level_release_delay_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_ON        = 2'd2,
        ST_FALL_WAIT = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        en_rise_q;
    logic        en_rise_d;
    logic        en_fall_q;
    logic        en_fall_d;

    // State, counter and edge-pulse registers; reset is asynchronous and immediate.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q   <= ST_OFF;
            cnt_q     <= 16'd0;
            en_rise_q <= 1'b0;
            en_fall_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            en_rise_q <= en_rise_d;
            en_fall_q <= en_fall_d;
        end
    end

    // Next-state, counter and pulse logic; delays are sampled live every cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        en_rise_d = 1'b0;
        en_fall_d = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (bus.enable) begin
                    if (bus.assert_delay == 16'd0) begin
                        state_d = ST_ON;
                        cnt_d   = 16'd0;
                    end else begin
                        state_d = ST_RISE_WAIT;
                        cnt_d   = 16'd1;
                    end
                end else begin
                    state_d = ST_OFF;
                    cnt_d   = 16'd0;
                end
            end
            ST_RISE_WAIT: begin
                if (!bus.enable) begin
                    // Abort: request vanished before qualification, no pulses.
                    state_d = ST_OFF;
                    cnt_d   = 16'd0;
                end else if (cnt_q >= bus.assert_delay) begin
                    state_d = ST_ON;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_RISE_WAIT;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            ST_ON: begin
                if (!bus.enable) begin
                    if (bus.release_delay == 16'd0) begin
                        state_d = ST_OFF;
                        cnt_d   = 16'd0;
                    end else begin
                        state_d = ST_FALL_WAIT;
                        cnt_d   = 16'd1;
                    end
                end else begin
                    state_d = ST_ON;
                    cnt_d   = 16'd0;
                end
            end
            ST_FALL_WAIT: begin
                if (bus.enable) begin
                    // Cancel: delayed_en never dropped, so no pulse either way.
                    state_d = ST_ON;
                    cnt_d   = 16'd0;
                end else if (cnt_q >= bus.release_delay) begin
                    state_d = ST_OFF;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_FALL_WAIT;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = 16'd0;
            end
        endcase

        if ((state_d == ST_ON) &&
            ((state_q == ST_OFF) || (state_q == ST_RISE_WAIT))) begin
            en_rise_d = 1'b1;
        end else begin
            en_rise_d = 1'b0;
        end

        if ((state_d == ST_OFF) &&
            ((state_q == ST_ON) || (state_q == ST_FALL_WAIT))) begin
            en_fall_d = 1'b1;
        end else begin
            en_fall_d = 1'b0;
        end
    end

    assign bus.delayed_en = (state_q == ST_ON) || (state_q == ST_FALL_WAIT);
    assign bus.busy       = (state_q == ST_RISE_WAIT) || (state_q == ST_FALL_WAIT);
    assign bus.en_rise    = en_rise_q;
    assign bus.en_fall    = en_fall_q;

endmodule

// File: tb/tb_level_release_delay.sv
// Directed self-checking bench for level_release_delay. Outputs are observed
// as the vector {delayed_en, busy, en_rise, en_fall} 1 ns after each rising edge.
module tb_level_release_delay;

    logic clk_core;
    logic rst_core_n;
    int   checks;
    int   failures;

    level_release_delay_if bus ();

    level_release_delay dut (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .bus        (bus.slave)
    );

    logic [3:0] obs;
    assign obs = {bus.delayed_en, bus.busy, bus.en_rise, bus.en_fall};

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    task automatic go_on();
        // From OFF, reach steady ON with assert_delay=0.
        bus.assert_delay = 16'd0;
        bus.enable = 1'b1;
        @(posedge clk_core); #1;
        @(posedge clk_core); #1;
    endtask

    task automatic go_off();
        bus.enable = 1'b0;
        bus.release_delay = 16'd0;
        @(posedge clk_core); #1;
        @(posedge clk_core); #1;
    endtask

    task automatic test_reset();
        rst_core_n = 1'b0;
        bus.enable = 1'b1;
        bus.assert_delay = 16'd0;
        bus.release_delay = 16'd0;
        repeat (3) @(posedge clk_core);
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold obs=%b expected=%b", obs, 4'b0000);
        end
        bus.enable = 1'b0;
        rst_core_n = 1'b1;
        @(posedge clk_core); #1;
        checks++;
        if (obs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release obs=%b expected=%b", obs, 4'b0000);
        end
    endtask

    task automatic test_assert3();
        logic [3:0] exp;
        bus.assert_delay = 16'd3;
        bus.release_delay = 16'd0;
        bus.enable = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(posedge clk_core); #1;
            if (k < 3)       exp = 4'b0100;
            else if (k == 3) exp = 4'b1010;
            else             exp = 4'b1000;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL assert3_k%0d obs=%b expected=%b", k, obs, exp);
            end
        end
        bus.enable = 1'b0;
        for (int k = 0; k <= 1; k++) begin
            @(posedge clk_core); #1;
            exp = (k == 0) ? 4'b0001 : 4'b0000;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL assert3_fall_k%0d obs=%b expected=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_short_high();
        logic [3:0] exp;
        bus.assert_delay = 16'd0;
        bus.release_delay = 16'd5;
        bus.enable = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            @(posedge clk_core); #1;
            bus.enable = 1'b0;
            if (k == 0)      exp = 4'b1010;
            else if (k <= 5) exp = 4'b1100;
            else if (k == 6) exp = 4'b0001;
            else             exp = 4'b0000;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL short_high_k%0d obs=%b expected=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_gap();
        logic [3:0] exp;
        go_on();
        bus.release_delay = 16'd8;
        for (int k = 0; k <= 6; k++) begin
            bus.enable = (k < 4) ? 1'b0 : 1'b1;
            @(posedge clk_core); #1;
            exp = (k < 4) ? 4'b1100 : 4'b1000;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL gap_k%0d obs=%b expected=%b", k, obs, exp);
            end
        end
        go_off();
    endtask

    task automatic test_short_pulse_and_max();
        logic [3:0] exp;
        int fail_prints;
        bus.assert_delay = 16'd6;
        for (int k = 0; k <= 5; k++) begin
            bus.enable = (k < 4) ? 1'b1 : 1'b0;
            @(posedge clk_core); #1;
            exp = (k < 4) ? 4'b0100 : 4'b0000;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL short_pulse_k%0d obs=%b expected=%b", k, obs, exp);
            end
        end
        go_on();
        bus.release_delay = 16'hFFFF;
        bus.enable = 1'b0;
        fail_prints = 0;
        for (int k = 0; k <= 65536; k++) begin
            @(posedge clk_core); #1;
            if (k < 65535)       exp = 4'b1100;
            else if (k == 65535) exp = 4'b0001;
            else                 exp = 4'b0000;
            checks++;
            if (obs !== exp) begin
                failures++;
                if (fail_prints < 10) begin
                    fail_prints++;
                    $display("FAIL max_release_k%0d obs=%b expected=%b", k, obs, exp);
                end
            end
        end
    endtask

    task automatic test_lower_delay();
        logic [3:0] exp;
        go_on();
        bus.release_delay = 16'd20;
        bus.enable = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (k == 7) bus.release_delay = 16'd2;
            @(posedge clk_core); #1;
            if (k <= 6)      exp = 4'b1100;
            else if (k == 7) exp = 4'b0001;
            else             exp = 4'b0000;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL lower_delay_k%0d obs=%b expected=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_fall();
        go_on();
        bus.release_delay = 16'd10;
        bus.enable = 1'b0;
        repeat (5) @(posedge clk_core);
        #1;
        checks++;
        if (obs !== 4'b1100) begin
            failures++;
            $display("FAIL mid_fall_pre obs=%b expected=%b", obs, 4'b1100);
        end
        #2;
        rst_core_n = 1'b0;
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            failures++;
            $display("FAIL mid_fall_reset obs=%b expected=%b", obs, 4'b0000);
        end
        @(posedge clk_core); #1;
        rst_core_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_core); #1;
            checks++;
            if (obs !== 4'b0000) begin
                failures++;
                $display("FAIL mid_fall_after_k%0d obs=%b expected=%b", k, obs, 4'b0000);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        bus.enable = 1'b0;
        bus.assert_delay = 16'd0;
        bus.release_delay = 16'd0;
        rst_core_n = 1'b0;
        test_reset();
        test_assert3();
        test_short_high();
        test_gap();
        test_lower_delay();
        go_off();
        test_reset_mid_fall();
        test_short_pulse_and_max();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
